// File: rtl/rgb2ycbcr_if.sv
// Pixel stream bundle for the RGB -> YCbCr converter: upstream RGB side and
// downstream YCbCr side, each with its own valid/ready pair.
interface rgb2ycbcr_if;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       vld_i;
    logic       rdy_o;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
    logic       blk_last_o;
    logic       vld_o;
    logic       rdy_i;

    // Valid/ready: a beat moves on a rising edge where valid and ready are both
    // high; the sender holds data stable while valid is high and ready is low.
    modport slave (
        input  r, g, b, vld_i, rdy_i,
        output rdy_o, y, cb, cr, blk_last_o, vld_o
    );

    modport master (
        output r, g, b, vld_i, rdy_i,
        input  rdy_o, y, cb, cr, blk_last_o, vld_o
    );
endinterface

// File: rtl/rgb2ycbcr.sv
// BT.601 studio-range RGB -> YCbCr converter: 3-stage shift-add pipeline with
// one global stall enable and a last-of-block tag every PIX_PER_BLK pixels.
module rgb2ycbcr #(
    parameter int PIX_PER_BLK = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    rgb2ycbcr_if.slave   bus
);
    localparam int CW = $clog2(PIX_PER_BLK);

    logic          en;
    logic          in_xfer;
    logic [CW-1:0] cnt;

    logic          v1, v2, v3;
    logic          l1, l2, l3;
    logic [15:0]   p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;
    logic [17:0]   s_y, s_cb, s_cr;
    logic [9:0]    ys, cbs, crs;
    logic [10:0]   t_y, t_cb, t_cr;
    logic [7:0]    y_q, cb_q, cr_q;
    logic [15:0]   r16, g16, b16;

    // The whole pipe moves as one; bubbles are not squeezed out during a stall.
    assign en        = !v3 || bus.rdy_i;
    assign in_xfer   = bus.vld_i && en;
    assign bus.rdy_o = en;

    assign r16 = {8'b0, bus.r};
    assign g16 = {8'b0, bus.g};
    assign b16 = {8'b0, bus.b};

    function automatic logic [7:0] sat8(input logic [10:0] v);
        if (v[10])
            return 8'd0;
        else if (v[9:8] != 2'b00)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (in_xfer)
            cnt <= cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; l1 <= 1'b0;
            p_yr <= '0; p_yg <= '0; p_yb <= '0;
            p_cbr <= '0; p_cbg <= '0; p_cbb <= '0;
            p_crr <= '0; p_crg <= '0; p_crb <= '0;
        end else if (en) begin
            v1    <= bus.vld_i;
            l1    <= in_xfer && (cnt == CW'(PIX_PER_BLK - 1));
            p_yr  <= (r16 << 6) + (r16 << 1);                 // 66
            p_yg  <= (g16 << 7) + g16;                        // 129
            p_yb  <= (b16 << 4) + (b16 << 3) + b16;           // 25
            p_cbr <= (r16 << 5) + (r16 << 2) + (r16 << 1);    // 38
            p_cbg <= (g16 << 6) + (g16 << 3) + (g16 << 1);    // 74
            p_cbb <= (b16 << 7) - (b16 << 4);                 // 112
            p_crr <= (r16 << 7) - (r16 << 4);                 // 112
            p_crg <= (g16 << 7) - (g16 << 5) - (g16 << 1);    // 94
            p_crb <= (b16 << 4) + (b16 << 1);                 // 18
        end
    end

    assign s_y  = 18'd128 + {2'b0, p_yr} + {2'b0, p_yg} + {2'b0, p_yb};
    assign s_cb = 18'd128 + {2'b0, p_cbb} - {2'b0, p_cbr} - {2'b0, p_cbg};
    assign s_cr = 18'd128 + {2'b0, p_crr} - {2'b0, p_crg} - {2'b0, p_crb};

    // Taking bits [17:8] of the two's complement sum is the floor shift by 8;
    // every result fits a signed 10-bit field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0; l2 <= 1'b0;
            ys <= '0; cbs <= '0; crs <= '0;
        end else if (en) begin
            v2  <= v1;
            l2  <= l1;
            ys  <= s_y[17:8];
            cbs <= s_cb[17:8];
            crs <= s_cr[17:8];
        end
    end

    assign t_y  = {ys[9], ys}   + 11'd16;
    assign t_cb = {cbs[9], cbs} + 11'd128;
    assign t_cr = {crs[9], crs} + 11'd128;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3 <= 1'b0; l3 <= 1'b0;
            y_q <= '0; cb_q <= '0; cr_q <= '0;
        end else if (en) begin
            v3   <= v2;
            l3   <= v2 && l2;
            y_q  <= v2 ? sat8(t_y)  : 8'd0;
            cb_q <= v2 ? sat8(t_cb) : 8'd0;
            cr_q <= v2 ? sat8(t_cr) : 8'd0;
        end
    end

    assign bus.vld_o      = v3;
    assign bus.blk_last_o = l3;
    assign bus.y          = y_q;
    assign bus.cb         = cb_q;
    assign bus.cr         = cr_q;
endmodule

// File: doc/rgb2ycbcr.md
Name: rgb2ycbcr

Overview:
- Encoder-side colour converter: 8-bit RGB pixels in, 8-bit BT.601 studio-range YCbCr out.
- It is the inverse of the decoder's YCbCr-to-RGB stage.
- Fixed 3-stage pipeline with valid/ready handshakes on both sides.
- Tags the 64th pixel of each 8x8 block so the downstream DCT/MCU buffer can frame blocks.

Parameters:
- PIX_PER_BLK, 64, pixels per block; must be a power of 2; sets counter width CW = log2(PIX_PER_BLK).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r, g, b  in  8 each  unsigned pixel components
- vld_i  in  1  input pixel valid
- rdy_o  out  1  block can accept input this cycle
- y, cb, cr  out  8 each  unsigned converted components
- blk_last_o  out  1  this output pixel is the last of its block
- vld_o  out  1  output pixel valid
- rdy_i  in  1  downstream accepts output

Behaviour:
- Reset: asynchronous, active-low.
  - Clears all stage valid bits and the pixel counter.
  - Forces y, cb, cr, blk_last_o and vld_o to 0.
  - Applies immediately, mid-pipeline included; in-flight pixels are discarded.
- Handshakes:
  - Input transfer when vld_i && rdy_o.
  - Output transfer when vld_o && rdy_i.
- Stall: single global enable, en = !vld_o || rdy_i; rdy_o = en.
  - All three stages advance together only when en = 1.
  - When en = 0, every stage register, including the outputs, holds its value.
  - Empty stages are not compacted while stalled.
  - Output data must not change while vld_o=1 and rdy_i=0.
- Latency and throughput:
  - Latency is exactly 3 enabled cycles from input accept to vld_o.
  - Throughput is 1 pixel/cycle while rdy_i=1.
- Stage 1: register the nine partial products using shift-add only, no multipliers.
  - Coefficients: 66,129,25 / 38,74,112 / 112,94,18.
- Stage 2: form signed 18-bit sums, then arithmetic shift right by 8 (floor).
  - Ys = (66R + 129G + 25B + 128) >>> 8
  - Cbs = (-38R - 74G + 112B + 128) >>> 8
  - Crs = (112R - 94G - 18B + 128) >>> 8
- Stage 3 (output register):
  - y = Ys + 16; cb = Cbs + 128; cr = Crs + 128.
  - Each result is saturated to 0..255 as a safety clamp; for legal inputs the results stay in 16..235 / 16..240.
  - When stage 3 holds no valid pixel, y, cb, cr and blk_last_o are 0.
- Block counter:
  - CW-bit counter, increments on each input transfer and wraps PIX_PER_BLK-1 to 0.
  - A pixel accepted while the counter equals PIX_PER_BLK-1 carries a last tag down the pipeline.
  - That tag appears on blk_last_o aligned with the pixel's vld_o.
  - The counter does not change when no input transfer occurs, including during a stall.
- Simultaneous output and input transfer in the same cycle is legal and lossless.
- With vld_i=1 and rdy_o=0, the upstream must hold r, g, b stable; the block does not sample them.

Test Plan:
- Reset mid-stream: 3 pixels in flight, pull rst_n low asynchronously between edges -> vld_o, y/cb/cr, blk_last_o drop to 0 before the next edge; the first pixel after release emerges 3 cycles after acceptance with blk_last_o=0 (counter restarted).
- Corner colours, rdy_i=1: (0,0,0)->(16,128,128); (255,255,255)->(235,128,128); (255,0,0)->(82,90,240); (0,0,255)->(41,240,110); each appears 3 cycles after acceptance.
- Back-to-back stream of 10 pixels, rdy_i=1: 10 consecutive vld_o cycles, order preserved, results match the formula model.
- Backpressure: stream with rdy_i=0 for 4 cycles mid-stream -> rdy_o=0, outputs held stable; no pixel lost or duplicated after release; the transfer in the release cycle is counted once.
- Block framing: 130 input pixels with random vld_i gaps -> blk_last_o=1 exactly on output pixels 64 and 128, and on no others.
- Random RGB, 10k pixels, random vld_i/rdy_i -> scoreboard exact match against the integer reference model; y in 16..235, cb/cr in 16..240.
